// File: rtl/spi_master_param.sv
// Purpose: SPI master with configurable word width, SCK divider, CPOL/CPHA mode and chip select.
// Latency: done is raised (2*DATA_W+2)*(div+1) cycles after the cycle following an accepted start.
// Backpressure: start is only accepted while idle; requests made while busy are dropped, not queued.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   start               - transfer request, sampled only in IDLE
//   din, cs_sel, div,   - transfer configuration, latched when start is accepted
//   cpol, cpha
//   miso                - serial data from the slave, sampled straight into the receive register
//   mosi, sck, cs_n     - registered serial interface outputs
//   dout                - last received word, updated together with the done pulse
//   busy, done          - busy from the cycle after accept to the end of the gap; one-cycle done pulse
module spi_master_param #(
    parameter int  DATA_W  = 32,
    parameter int  NUM_CS  = 4,
    parameter int  DIV_W   = 8,
    parameter int  GAP_CYC = 8,
    localparam int SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [EDGE_W-1:0] LAST_EDGE     = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] PRE_LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST      = GAP_W'(GAP_CYC - 1);

    state_t              state_q,  state_d;
    logic [DIV_W-1:0]    hp_cnt_q, hp_cnt_d;
    logic [DIV_W-1:0]    div_q,    div_d;
    logic [EDGE_W-1:0]   edge_q,   edge_d;
    logic [GAP_W-1:0]    gap_q,    gap_d;
    logic [DATA_W-1:0]   tx_q,     tx_d;
    logic [DATA_W-1:0]   rx_q,     rx_d;
    logic [DATA_W-1:0]   dout_q,   dout_d;
    logic                cpol_q,   cpol_d;
    logic                cpha_q,   cpha_d;
    logic                sck_q,    sck_d;
    logic                mosi_q,   mosi_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [NUM_CS-1:0]   cs_n_q,   cs_n_d;

    logic [NUM_CS-1:0]   cs_dec;
    logic                hp_expired;
    logic                fire_edge;
    logic                leading;

    // An out-of-range index matches no line, so every chip select stays high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == SEL_W'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hp_cnt_d   = hp_cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        dout_d     = dout_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_n_d     = cs_n_q;
        fire_edge  = 1'b0;
        hp_expired = (hp_cnt_q == div_q);
        // edge_q counts edges already issued, so the next one is odd (leading) when edge_q is even.
        leading    = ~edge_q[0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETUP;
                    hp_cnt_d = '0;
                    edge_d   = '0;
                    div_d    = div;
                    cpol_d   = cpol;
                    cpha_d   = cpha;
                    tx_d     = din;
                    sck_d    = cpol;
                    // Mode with cpha=0 must have the MSB on the wire before the first edge.
                    mosi_d   = cpha ? 1'b0 : din[DATA_W-1];
                    cs_n_d   = cs_dec;
                    busy_d   = 1'b1;
                end
            end
            S_SETUP: begin
                if (hp_expired) begin
                    hp_cnt_d  = '0;
                    fire_edge = 1'b1;
                    state_d   = S_XFER;
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_W'(1);
                end
            end
            S_XFER: begin
                // Each half-period starts with an edge; the half-period after the final
                // edge carries sck back at cpol before HOLD begins.
                if (hp_expired) begin
                    hp_cnt_d = '0;
                    if (edge_q == LAST_EDGE) begin
                        state_d = S_HOLD;
                    end else begin
                        fire_edge = 1'b1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (hp_expired) begin
                    hp_cnt_d = '0;
                    cs_n_d   = '1;
                    done_d   = 1'b1;
                    dout_d   = rx_q;
                    mosi_d   = 1'b0;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end else begin
                    hp_cnt_d = hp_cnt_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fire_edge) begin
            sck_d  = ~sck_q;
            edge_d = edge_q + EDGE_W'(1);
            // miso is taken on the clk edge that launches the sampling sck edge.
            if (leading ^ cpha_q) begin
                rx_d = {rx_q[DATA_W-2:0], miso};
            end
            if (cpha_q && leading) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end else if (!cpha_q && !leading && (edge_q != PRE_LAST_EDGE)) begin
                // MSB already went out at accept, so the next bit is one below the top.
                mosi_d = tx_q[DATA_W-2];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hp_cnt_q <= '0;
            div_q    <= '0;
            edge_q   <= '0;
            gap_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= '1;
        end else begin
            state_q  <= state_d;
            hp_cnt_q <= hp_cnt_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            gap_q    <= gap_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
        end
    end

    assign mosi = mosi_q;
    assign sck  = sck_q;
    assign cs_n = cs_n_q;
    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Purpose: directed bench for spi_master_param with a cycle-level reference model and an SPI slave.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_spi_master_param;

    localparam int N   = 32;
    localparam int NCS = 4;
    localparam int DW  = 8;
    localparam int GAP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  din = '0;
    logic [1:0]    cs_sel = '0;
    logic [DW-1:0] div = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          miso;
    logic          mosi;
    logic          sck;
    logic [NCS-1:0] cs_n;
    logic [N-1:0]  dout;
    logic          busy;
    logic          done;

    spi_master_param #(
        .DATA_W (N),
        .NUM_CS (NCS),
        .DIV_W  (DW),
        .GAP_CYC(GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .cs_sel(cs_sel),
        .div   (div),
        .cpol  (cpol),
        .cpha  (cpha),
        .miso  (miso),
        .mosi  (mosi),
        .sck   (sck),
        .cs_n  (cs_n),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // ---------------- slave / loopback ----------------
    bit          loopback = 1'b1;
    logic [N-1:0] reply = '0;
    bit          s_cpol = 1'b0;
    bit          s_cpha = 1'b0;
    logic        slave_miso = 1'b0;
    logic [N-1:0] sl_rx = '0;
    int          sl_bit = 0;
    bit          sl_in = 1'b0;
    logic        cs_any;

    assign cs_any = &cs_n;
    assign miso   = loopback ? mosi : slave_miso;

    always @(negedge cs_any) begin
        sl_rx = '0;
        sl_in = 1'b0;
        if (s_cpha) begin
            slave_miso = 1'b0;
            sl_bit     = N - 1;
        end else begin
            slave_miso = reply[N-1];
            sl_bit     = N - 2;
        end
    end

    always @(sck) begin
        if (cs_any === 1'b0) begin
            if (sck !== s_cpol) begin
                sl_in = 1'b1;
                if (!s_cpha) begin
                    sl_rx = {sl_rx[N-2:0], mosi};
                end else begin
                    if (sl_bit >= 0) slave_miso = reply[sl_bit];
                    sl_bit--;
                end
            end else if (sl_in) begin
                sl_in = 1'b0;
                if (s_cpha) begin
                    sl_rx = {sl_rx[N-2:0], mosi};
                end else begin
                    if (sl_bit >= 0) slave_miso = reply[sl_bit];
                    sl_bit--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // m_c is the offset of the current cycle from the accept cycle T (1 = first busy cycle).
    bit           m_act = 1'b0;
    int           m_c = 0;
    int           m_h = 1;
    logic [N-1:0] m_din = '0;
    logic [1:0]   m_sel = '0;
    logic         m_cpol = 1'b0;
    logic         m_cpha = 1'b0;
    logic         m_last_cpol = 1'b0;
    logic [N-1:0] m_rx = '0;
    logic [N-1:0] m_dout = '0;
    bit           m_was_idle;

    always @(posedge clk) begin
        m_was_idle = !m_act;
        if (rst) begin
            m_act       = 1'b0;
            m_last_cpol = 1'b0;
            m_dout      = '0;
        end else begin
            if (m_act) begin
                m_c++;
                if (m_c == 1 + (2 * N + 2) * m_h) m_dout = m_rx;
                if (m_c > (2 * N + 2) * m_h + GAP) m_act = 1'b0;
            end
            if (m_was_idle && start) begin
                m_act       = 1'b1;
                m_c         = 1;
                m_h         = int'(div) + 1;
                m_din       = din;
                m_sel       = cs_sel;
                m_cpol      = cpol;
                m_cpha      = cpha;
                m_last_cpol = cpol;
                m_rx        = loopback ? din : reply;
            end
        end
    end

    int       e_hp, e_bi, e_span;
    logic     e_busy, e_done, e_sck, e_mosi;
    logic [NCS-1:0] e_csn;

    always @(negedge clk) begin
        e_span = (2 * N + 2) * m_h;
        e_busy = m_act;
        e_done = m_act && (m_c == e_span + 1);
        e_csn  = '1;
        e_sck  = m_last_cpol;
        e_mosi = 1'b0;
        if (m_act && m_c <= e_span) begin
            e_hp = (m_c - 1) / m_h;
            e_csn[m_sel] = 1'b0;
            if (e_hp >= 1 && e_hp <= 2 * N) e_sck = m_cpol ^ (e_hp % 2 == 1);
            if (!m_cpha) begin
                e_bi = N - 1 - ((e_hp / 2 < N - 1) ? e_hp / 2 : N - 1);
            end else if (e_hp == 0) begin
                e_bi = -1;
            end else begin
                e_bi = N - 1 - (((e_hp - 1) / 2 < N - 1) ? (e_hp - 1) / 2 : N - 1);
            end
            e_mosi = (e_bi >= 0) ? m_din[e_bi] : 1'b0;
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("cs_n", cs_n, e_csn);
        check("sck",  sck,  e_sck);
        check("mosi", mosi, e_mosi);
        check("dout", dout, m_dout);
    end

    // ---------------- helpers ----------------
    int  n_done_seen = 0;
    bit  cnt_en = 1'b0;
    int  sck_edges = 0;

    always @(negedge clk) if (done === 1'b1) n_done_seen++;
    always @(sck) if (cnt_en) sck_edges++;

    task automatic launch(input logic [N-1:0] d, input logic [1:0] sel, input logic [DW-1:0] dv,
                          input logic p, input logic h, output int t1);
        @(negedge clk);
        din = d; cs_sel = sel; div = dv; cpol = p; cpha = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t1 = cyc_n;
    endtask

    task automatic wait_done(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc_n;
                break;
            end
        end
        if (at < 0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                at = cyc_n;
                break;
            end
        end
        if (at < 0) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    int t1, t_done, t_idle, d0, run;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_sck",  sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout", dout, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0 loopback, div=0.
        loopback = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0;
        launch(32'hA5C30F81, 2'd0, 8'd0, 1'b0, 1'b0, t1);
        check("m0_cs_first", cs_n, 4'b1110);
        sck_edges = 0; cnt_en = 1'b1;
        wait_done(200, t_done);
        cnt_en = 1'b0;
        check("m0_done_at", t_done - (t1 - 1), 67);
        check("m0_dout", dout, 32'hA5C30F81);
        check("m0_edges", sck_edges, 64);
        wait_idle(50, t_idle);
        check("m0_idle_at", t_idle - (t1 - 1), 75);

        // Mode 3, div=3, slave on cs 2.
        loopback = 1'b0; reply = 32'h12345678; s_cpol = 1'b1; s_cpha = 1'b1;
        launch(32'hDEADBEEF, 2'd2, 8'd3, 1'b1, 1'b1, t1);
        check("m3_cs_first", cs_n, 4'b1011);
        check("m3_sck_setup", sck, 1'b1);
        wait_done(400, t_done);
        check("m3_done_at", t_done - (t1 - 1), 1 + 66 * 4);
        check("m3_dout", dout, 32'h12345678);
        check("m3_slave_rx", sl_rx, 32'hDEADBEEF);
        wait_idle(50, t_idle);
        check("m3_sck_idle", sck, 1'b1);

        // Mode 1, div=1.
        reply = 32'hC3A50F1E; s_cpol = 1'b0; s_cpha = 1'b1;
        launch(32'h0000FFFF, 2'd1, 8'd1, 1'b0, 1'b1, t1);
        wait_done(300, t_done);
        check("m1_dout", dout, 32'hC3A50F1E);
        check("m1_slave_rx", sl_rx, 32'h0000FFFF);
        wait_idle(50, t_idle);

        // Mode 2, div=2.
        reply = 32'h8001F00D; s_cpol = 1'b1; s_cpha = 1'b0;
        launch(32'h0000FFFF, 2'd3, 8'd2, 1'b1, 1'b0, t1);
        wait_done(400, t_done);
        check("m2_dout", dout, 32'h8001F00D);
        check("m2_slave_rx", sl_rx, 32'h0000FFFF);
        wait_idle(50, t_idle);

        // Config changes and a second start while busy.
        loopback = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0;
        d0 = n_done_seen;
        launch(32'h13579BDF, 2'd1, 8'd1, 1'b0, 1'b0, t1);
        repeat (9) @(negedge clk);
        din = 32'h2468ACE0; cs_sel = 2'd3; div = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, t_done);
        check("mid_done_at", t_done - (t1 - 1), 1 + 66 * 2);
        check("mid_dout", dout, 32'h13579BDF);
        wait_idle(50, t_idle);
        check("mid_done_count", n_done_seen - d0, 1);
        launch(32'h2468ACE0, 2'd3, 8'd5, 1'b0, 1'b0, t1);
        wait_done(600, t_done);
        check("mid2_done_at", t_done - (t1 - 1), 1 + 66 * 6);
        check("mid2_dout", dout, 32'h2468ACE0);
        wait_idle(50, t_idle);

        // Reset on the clk edge that launches sck edge 20.
        launch(32'hFEDCBA98, 2'd0, 8'd1, 1'b0, 1'b0, t1);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_cs_n", cs_n, 4'hF);
        check("rst_mid_sck",  sck, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_dout", dout, 32'h0);
        d0 = n_done_seen;
        repeat (150) @(negedge clk);
        check("rst_no_done", n_done_seen - d0, 0);
        launch(32'h0F0F1234, 2'd3, 8'd0, 1'b0, 1'b0, t1);
        wait_done(200, t_done);
        check("post_rst_done_at", t_done - (t1 - 1), 67);
        check("post_rst_dout", dout, 32'h0F0F1234);
        wait_idle(50, t_idle);

        // Back-to-back with start held high.
        d0 = n_done_seen;
        @(negedge clk);
        din = 32'h11111111; cs_sel = 2'd1; div = 8'd0; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        @(negedge clk);
        t1 = cyc_n;
        din = 32'h22222222;
        wait_done(200, t_done);
        check("b2b_first_done_at", t_done - (t1 - 1), 67);
        check("b2b_first_dout", dout, 32'h11111111);
        run = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cs_n === 4'hF) begin
                run++;
            end else begin
                break;
            end
        end
        start = 1'b0;
        t1 = cyc_n;
        check("b2b_gap_ge8", run >= GAP, 1);
        check("b2b_cs_second", cs_n, 4'b1101);
        wait_done(200, t_done);
        check("b2b_second_done_at", t_done - (t1 - 1), 67);
        check("b2b_second_dout", dout, 32'h22222222);
        wait_idle(50, t_idle);
        check("b2b_done_count", n_done_seen - d0, 2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parameterised SPI master; next generation of the fixed 32-bit, free-running SPI block.
- Adds configurable word width, programmable SCK divider, all four CPOL/CPHA modes, multiple chip selects and an explicit start/busy/done handshake.
- Sits between the system-clock control logic and external SPI peripherals (ROM, ADC, DAC). One word is transferred per start request.

Parameters:
- DATA_W, 32: bits per transfer, MSB first; legal range 4..64.
- NUM_CS, 4: number of active-low chip selects; SEL_W = max(1, clog2(NUM_CS)).
- DIV_W, 8: width of the div input.
- GAP_CYC, 8: minimum clk cycles with all cs_n high between transfers; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transfer request; sampled only in IDLE.
- din  in  DATA_W  word to transmit; latched on accepted start.
- cs_sel  in  SEL_W  chip-select index; latched on accepted start.
- div  in  DIV_W  half-period = div+1 clk cycles; latched on accepted start.
- cpol  in  1  SCK idle level; latched on accepted start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accepted start.
- miso  in  1  serial data from the slave.
- mosi  out  1  serial data to the slave (registered).
- sck  out  NUM_CS-independent 1  serial clock (registered).
- cs_n  out  NUM_CS  one-hot-low chip selects (registered).
- dout  out  DATA_W  last received word; holds its value between transfers.
- busy  out  1  high from the cycle after an accepted start to the end of GAP.
- done  out  1  one-cycle pulse on completion; dout is valid in the same cycle.

Behaviour:
- Reset values: sck=0, mosi=0, cs_n=all 1, dout=0, busy=0, done=0, latched cpol=0, state=IDLE.
- Reset mid-transfer aborts on the next edge and forces the reset values. No done pulse is generated. dout is cleared to 0.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE: start=1 at cycle T latches din, cs_sel, div, cpol and cpha. At T+1: busy=1, cs_n[cs_sel]=0, state=SETUP.
- start while busy=1 is ignored, with no queueing. start held high in IDLE begins a new transfer on the first IDLE cycle.
- SETUP lasts div+1 cycles. sck = latched cpol. For cpha=0, mosi = din[DATA_W-1] throughout SETUP.
- XFER: a half-period counter runs div+1 cycles; sck toggles at each expiry, giving exactly 2*DATA_W edges in total.
  - Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
- cpha=0:
  - miso is sampled into the receive shift register on each leading edge.
  - mosi advances to the next bit on each trailing edge, except after the final edge.
- cpha=1:
  - mosi advances on each leading edge; the first leading edge presents the MSB.
  - miso is sampled on each trailing edge.
  - mosi = 0 during SETUP.
- SCK frequency is clk/(2*(div+1)). div=0 gives clk/2.
- After the last edge, sck has returned to cpol. HOLD then lasts div+1 cycles with cs_n still low.
- On HOLD exit:
  - cs_n goes to all 1.
  - done=1 for exactly one cycle.
  - dout is loaded from the receive shift register in that same cycle.
  - State becomes GAP.
- GAP: GAP_CYC cycles with busy=1 and mosi=0. The FSM then enters IDLE, where busy=0.
- Total busy duration: (2*DATA_W+2)*(div+1)+GAP_CYC cycles. done occurs at cycle T+1+(2*DATA_W+2)*(div+1).
- Out-of-range cs_sel (>= NUM_CS): the transfer runs with normal timing and done, but no cs_n line is asserted.
- Changes to the config inputs while busy have no effect on the current transfer.
- miso is sampled on the same clk edge that produces the sampling SCK edge. The receive register samples miso directly, so no extra synchronisation delay is added.

Test Plan:
- Loopback (mosi tied to miso), DATA_W=32, div=0, mode 0, cs_sel=0, din=0xA5C30F81, start at T: cs_n=4'b1110 from T+1; exactly 64 sck edges; done at T+67; dout=0xA5C30F81; busy low at T+75.
- Mode 3 (cpol=1, cpha=1), div=3, slave model returns 0x12345678 on cs_sel=2:
  - sck idles high and each half-period is 4 cycles.
  - Only cs_n[2] goes low.
  - The slave captures din=0xDEADBEEF on rising edges.
  - dout=0x12345678.
- Modes 1 and 2 with slave model, din=0x0000FFFF: the bit-exact MSB-first sequence on mosi is checked against the model at the correct sampling edges, and dout matches the model's reply for both modes.
- start pulsed again 10 cycles into a transfer, and cs_sel/div changed mid-transfer: no effect on the current transfer and exactly one done pulse. A start asserted after busy falls produces a second transfer.
- rst asserted during XFER edge 20:
  - Next cycle: cs_n=all 1, sck=0, busy=0, dout=0.
  - No done pulse.
  - A fresh start afterwards completes normally.
- Back-to-back with start held high, GAP_CYC=8: cs_n is high for ≥8 cycles between the two transfers, and two done pulses are generated with correct dout values.
